// File: rtl/fft_pkg.sv
// Shared constants, sequencer state encoding and address helpers for the
// 256-point radix-2 DIF FFT sequencer.
package fft_pkg;
  localparam int N_LOG2   = 8;
  localparam int N        = 1 << N_LOG2;
  localparam int BF_COUNT = N / 2;

  typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, UNLOAD} state_e;

  function automatic logic [7:0] bitrev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Sample streams and butterfly issue bus between the FFT sequencer (master)
// and the RAM / butterfly datapath (slave).
interface fft_seq_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] wr_addr;
  logic       bf_valid;
  logic [7:0] addr_a;
  logic [7:0] addr_b;
  logic [6:0] tw_idx;
  logic [2:0] stage;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] rd_addr;

  modport master (
    input  in_valid, out_ready,
    output in_ready, wr_addr, bf_valid, addr_a, addr_b, tw_idx, stage,
           out_valid, rd_addr
  );
  modport slave (
    output in_valid, out_ready,
    input  in_ready, wr_addr, bf_valid, addr_a, addr_b, tw_idx, stage,
           out_valid, rd_addr
  );
endinterface

// File: rtl/fft_addr_gen.sv
// Butterfly operand / twiddle address decode for one DIF stage: splits k at
// bit (7-stage) and inserts the pair-select bit there.
module fft_addr_gen (
  input  logic [2:0] stage,
  input  logic [6:0] k,
  output logic [7:0] addr_a,
  output logic [7:0] addr_b,
  output logic [6:0] tw_idx
);
  logic [7:0] span, mask, kx;

  assign span   = 8'd1 << (3'd7 - stage);
  assign mask   = span - 8'd1;
  assign kx     = {1'b0, k};
  // high part of k moves up one bit to open a zero at the span position
  assign addr_a = ((kx & ~mask) << 1) | (kx & mask);
  assign addr_b = addr_a | span;
  assign tw_idx = 7'((kx & mask) << stage);
endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for the 256-point in-place DIF FFT: LOAD, 8x(CALC+DRAIN),
// bit-reversed UNLOAD. Optional inverse-FFT control under FFT_SEQ_CTRL_IFFT_EN.
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int BF_LAT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
`ifdef FFT_SEQ_CTRL_IFFT_EN
  input  logic           inv,
  output logic           tw_conj,
`endif
  fft_seq_ctrl_if.master bus,
  output logic           busy,
  output logic           done
);
  state_e            state;
  logic [N_LOG2-1:0] cnt;
  logic [N_LOG2-2:0] k;
  logic [2:0]        stg;
  logic [3:0]        dcnt;
  logic [7:0]        ag_a, ag_b;
  logic [6:0]        ag_tw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      k     <= '0;
      stg   <= '0;
      dcnt  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          state <= LOAD;
          cnt   <= '0;
        end
        LOAD: if (bus.in_valid) begin
          cnt <= cnt + 1'b1;  // wraps to 0 on exit, ready for UNLOAD reuse
          if (&cnt) begin
            state <= CALC;
            stg   <= '0;
            k     <= '0;
          end
        end
        CALC: begin
          k <= k + 1'b1;
          if (&k) begin
            state <= DRAIN;
            dcnt  <= '0;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == 4'(BF_LAT - 1)) begin
            if (stg == 3'(N_LOG2 - 1)) begin
              state <= UNLOAD;
              cnt   <= '0;
            end else begin
              stg   <= stg + 1'b1;
              state <= CALC;
            end
          end
        end
        UNLOAD: if (bus.out_ready) begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= IDLE;
            stg   <= '0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FFT_SEQ_CTRL_IFFT_EN
  logic inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     inv_q <= 1'b0;
    else if (state == IDLE && start) inv_q <= inv;
  end

  assign tw_conj = inv_q && (state == CALC);
`endif

  fft_addr_gen u_addr_gen (
    .stage  (stg),
    .k      (k),
    .addr_a (ag_a),
    .addr_b (ag_b),
    .tw_idx (ag_tw)
  );

  // addresses are forced to 0 outside their phase so idle outputs stay quiet
  assign bus.in_ready  = (state == LOAD);
  assign bus.wr_addr   = bus.in_ready ? cnt : '0;
  assign bus.bf_valid  = (state == CALC);
  assign bus.addr_a    = bus.bf_valid ? ag_a  : '0;
  assign bus.addr_b    = bus.bf_valid ? ag_b  : '0;
  assign bus.tw_idx    = bus.bf_valid ? ag_tw : '0;
  assign bus.stage     = stg;
  assign bus.out_valid = (state == UNLOAD);
  assign bus.rd_addr   = bus.out_valid ? bitrev8(cnt) : '0;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed/randomized bench for fft_seq_ctrl against an arithmetic model of
// butterfly pairing, twiddle indexing and bit-reversed unload.
module tb_fft_seq_ctrl;
  localparam int BF_LAT = 4;
  localparam int FRAME  = 256 + 8 * (128 + BF_LAT) + 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
`ifdef FFT_SEQ_CTRL_IFFT_EN
  logic inv = 1'b0;
  logic tw_conj;
  logic inv_exp = 1'b0;
`endif

  fft_seq_ctrl_if bus ();

  fft_seq_ctrl #(.BF_LAT(BF_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef FFT_SEQ_CTRL_IFFT_EN
    .inv     (inv),
    .tw_conj (tw_conj),
`endif
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_cmp++;
    assert (obs === 32'(expv)) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Stage s pairs element a with a+span; the k-th pair is the k-th a whose
  // span bit is clear, counted in ascending order.
  function automatic int span_of(input int s);
    return 128 >> s;
  endfunction
  function automatic int exp_a(input int s, input int k);
    return (k / span_of(s)) * 2 * span_of(s) + (k % span_of(s));
  endfunction
  function automatic int exp_tw(input int s, input int k);
    return ((k % span_of(s)) * (1 << s)) % 128;
  endfunction
  function automatic int rev8(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < 8; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic chk_all_zero(input string p);
    chk({p, "_busy"},      busy,          0);
    chk({p, "_done"},      done,          0);
    chk({p, "_in_ready"},  bus.in_ready,  0);
    chk({p, "_wr_addr"},   bus.wr_addr,   0);
    chk({p, "_bf_valid"},  bus.bf_valid,  0);
    chk({p, "_addr_a"},    bus.addr_a,    0);
    chk({p, "_addr_b"},    bus.addr_b,    0);
    chk({p, "_tw_idx"},    bus.tw_idx,    0);
    chk({p, "_stage"},     bus.stage,     0);
    chk({p, "_out_valid"}, bus.out_valid, 0);
    chk({p, "_rd_addr"},   bus.rd_addr,   0);
  endtask

  task automatic set_inv();
`ifdef FFT_SEQ_CTRL_IFFT_EN
    inv     = 1'($urandom);
    inv_exp = inv;
`endif
  endtask

  task automatic kick();
    set_inv();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge of the first LOAD cycle; leaves after the cycle
  // following done, or mid-CALC when stage abort_s reaches k=20.
  task automatic run_frame(input bit bp, input bit stall, input int abort_s,
                           input bit launch_next, output int cyc);
    int i = 0;
    int j = 0;
    int hold = 0;
    cyc = 0;
    while (i < 256) begin
      chk("load_in_ready", bus.in_ready, 1);
      chk("load_wr_addr", bus.wr_addr, i);
      chk("load_bf_valid", bus.bf_valid, 0);
      if (busy) cyc++;
      bus.in_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.in_valid) i++;
      @(negedge clk);
    end
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 128; k++) begin
        if (s == abort_s && k == 20) return;
        chk($sformatf("bf_valid s%0d k%0d", s, k), bus.bf_valid, 1);
        chk($sformatf("stage s%0d k%0d", s, k), bus.stage, s);
        chk($sformatf("addr_a s%0d k%0d", s, k), bus.addr_a, exp_a(s, k));
        chk($sformatf("addr_b s%0d k%0d", s, k), bus.addr_b, exp_a(s, k) + span_of(s));
        chk($sformatf("tw_idx s%0d k%0d", s, k), bus.tw_idx, exp_tw(s, k));
        chk("calc_in_ready", bus.in_ready, 0);
`ifdef FFT_SEQ_CTRL_IFFT_EN
        chk("tw_conj", tw_conj, int'(inv_exp));
        inv = 1'($urandom);
`endif
        if (busy) cyc++;
        start        = 1'($urandom);
        bus.in_valid = 1'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
      for (int d = 0; d < BF_LAT; d++) begin
        chk($sformatf("drain_bf_valid s%0d d%0d", s, d), bus.bf_valid, 0);
        chk("drain_busy", busy, 1);
        chk("drain_stage", bus.stage, s);
        if (busy) cyc++;
        @(negedge clk);
      end
    end
    while (j < 256) begin
      chk("unload_out_valid", bus.out_valid, 1);
      chk($sformatf("rd_addr j%0d", j), bus.rd_addr, rev8(j));
      if (busy) cyc++;
      if (stall && j == 2 && hold < 3) begin
        bus.out_ready = 1'b0;
        hold++;
      end else begin
        bus.out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (bus.out_ready) j++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_out_valid", bus.out_valid, 0);
    if (launch_next) set_inv();
    start = launch_next;
    @(negedge clk);
    start = 1'b0;
    chk("done_once", done, 0);
    if (!launch_next) chk("idle_busy", busy, 0);
  endtask

  initial begin
    int cyc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");

    rst_n         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("idle_ign_busy", busy, 0);
    chk("idle_ign_in_ready", bus.in_ready, 0);

    // clean frame, chained into a backpressured frame via start on done
    kick();
    run_frame(1'b0, 1'b0, -1, 1'b1, cyc);
    chk("frame_len", cyc, FRAME);
    run_frame(1'b1, 1'b1, -1, 1'b0, cyc);

    // abort at stage 3
    kick();
    run_frame(1'b1, 1'b0, 3, 1'b0, cyc);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end

    kick();
    run_frame(1'b0, 1'b0, -1, 1'b0, cyc);
    chk("frame_len2", cyc, FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
